wb_port_arbiter: RTL and testbench

Arbiter that shares the single register-file write port between two writeback sources: the in-order pipeline writeback (port A) and the out-of-band load/multi-cycle return path (port B). Port B results are buffered in a small pending FIFO. Port A has priority, with a starvation limit and an ordering guard for same-register writes. It sits between the writeback stage / memory return path and the register file, and drives the register file's write port.

---
 rtl/wb_port_arbiter_pkg.sv | 14 +
 rtl/wb_pend_fifo.sv | 74 +++++++
 rtl/wb_port_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Circular pending FIFO for port B writeback results.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module wb_pend_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  wb_req_t                             push_req,
  input  logic                                pop,
  output wb_req_t                             head,
  output logic                                empty,
  output logic                                full,
  output logic [DEPTH-1:0]                    entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_addr
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]               wr_ptr_q, wr_ptr_d;
  logic [AW:0]               rd_ptr_q, rd_ptr_d;
  logic [AW:0]               count;
  logic [AW-1:0]             offset;
  wb_req_t [DEPTH-1:0]       mem_q, mem_d;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointers and storage for push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_req;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    offset      = '0;
    entry_valid = '0;
    entry_addr  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset         = AW'(i) - rd_ptr_q[AW-1:0];
      entry_valid[i] = ({1'b0, offset} < count);
      entry_addr[i]  = mem_q[i].addr;
    end
  end

  // Pointer and storage registers; reset empties the queue immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback (A) and
// the buffered load/multi-cycle return path (B). A has priority, bounded by a
// starvation limit and an ordering guard for same-register writes.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned B_DEPTH      = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [XLEN-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] busy_addr,
  output logic                  busy_hit,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]       write_data
);

  localparam int unsigned SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  wb_req_t                             head;
  logic                                empty, full, nonempty;
  logic [B_DEPTH-1:0]                  entry_valid;
  logic [B_DEPTH-1:0][REG_ADDR_W-1:0]  entry_addr;
  logic                                b_push, force_b, conflict, grant_b, a_take;

  logic [SW-1:0]         starve_q, starve_d;
  logic                  write_enable_q, write_enable_d;
  logic [REG_ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [XLEN-1:0]       write_data_q, write_data_d;

  wb_pend_fifo #(
    .DEPTH (B_DEPTH)
  ) u_fifo (
    .clk         (clk_in),
    .rst         (rst_in),
    .push        (b_push),
    .push_req    ('{addr: b_addr, data: b_data}),
    .pop         (grant_b),
    .head        (head),
    .empty       (empty),
    .full        (full),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Grant decision: B wins when forced, when A would overtake an older same-register write, or when A is idle.
  always_comb begin
    nonempty = !empty;
    b_ready  = rdy_in && !full;
    b_push   = b_valid && b_ready && (b_addr != ZERO_REG);
    force_b  = nonempty && (starve_q == STARVE_MAX);
    conflict = a_valid && nonempty && (a_addr == head.addr) && (a_addr != ZERO_REG);
    grant_b  = rdy_in && nonempty && (force_b || conflict || !a_valid);
    a_ready  = rdy_in && !grant_b;
    a_take   = a_valid && a_ready;
  end

  // Register-pending query against every live FIFO entry.
  always_comb begin
    busy_hit = 1'b0;
    if (busy_addr != ZERO_REG) begin
      for (int unsigned i = 0; i < B_DEPTH; i++) begin
        if (entry_valid[i] && (entry_addr[i] == busy_addr)) busy_hit = 1'b1;
      end
    end
  end

  // Next write-port contents and starvation count.
  always_comb begin
    write_enable_d = 1'b0;
    write_addr_d   = '0;
    write_data_d   = '0;
    starve_d       = starve_q;
    if (grant_b) begin
      write_enable_d = 1'b1;
      write_addr_d   = head.addr;
      write_data_d   = head.data;
    end else if (a_take && (a_addr != ZERO_REG)) begin
      write_enable_d = 1'b1;
      write_addr_d   = a_addr;
      write_data_d   = a_data;
    end
    if (rdy_in) begin
      if (grant_b || empty)          starve_d = '0;
      else if (starve_q != STARVE_MAX) starve_d = starve_q + STARVE_ONE;
    end
  end

  // Output registers and starve counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      starve_q       <= '0;
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
    end else begin
      starve_q       <= starve_d;
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
    end
  end

  assign write_enable = write_enable_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: per-cycle vector table plus a write scoreboard.
module tb_wb_port_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr, busy_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, busy_hit, write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rdy, av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic [4:0]  qa;
    logic        ar, br, bh, we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];

  wb_port_arbiter #(
    .B_DEPTH      (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .busy_addr    (busy_addr),
    .busy_hit     (busy_hit),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s v%0d: got %h want %h", nm, idx, got, want);
    end
  endtask

  function automatic vec_t mk(input logic rdy, av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                              input logic [4:0] qa, input logic ar, br, bh, we,
                              input logic [4:0] wa, input logic [31:0] wd);
    vec_t v;
    v.rdy = rdy; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd; v.qa = qa;
    v.ar = ar; v.br = br; v.bh = bh; v.we = we; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk_in) begin
    wr_t e;
    if (write_enable === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got addr %h data %h want no write", write_addr, write_data);
      end else begin
        e = sb.pop_front();
        chk("sb_addr", 0, 32'(write_addr), 32'(e.a));
        chk("sb_data", 0, write_data, e.d);
      end
    end
  end

  // Drive one cycle at posedge+1, check combinational outputs, then registered ones after the edge.
  task automatic step(input int idx, input vec_t v);
    wr_t e;
    rdy_in = v.rdy; a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    b_valid = v.bv; b_addr = v.ba; b_data = v.bd; busy_addr = v.qa;
    #2;
    chk("a_ready", idx, 32'(a_ready), 32'(v.ar));
    chk("b_ready", idx, 32'(b_ready), 32'(v.br));
    chk("busy_hit", idx, 32'(busy_hit), 32'(v.bh));
    if (v.we) begin
      e.a = v.wa;
      e.d = v.wd;
      sb.push_back(e);
    end
    @(posedge clk_in);
    #1;
    chk("write_enable", idx, 32'(write_enable), 32'(v.we));
    chk("write_addr", idx, 32'(write_addr), 32'(v.wa));
    chk("write_data", idx, write_data, v.wd);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    // A only
    repeat (3) vecs.push_back(mk(1,1,5,'h1234,0,0,0,0, 1,1,0, 1,5,'h1234));
    // B only, latency 2 and one-cycle busy window
    vecs.push_back(mk(1,0,0,0,1,7,'hCAFE,7, 1,1,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,7,      0,1,1, 1,7,'hCAFE));
    vecs.push_back(mk(1,0,0,0,0,0,0,7,      1,1,0, 0,0,0));
    // Starvation: three A wins, then x2 forced
    vecs.push_back(mk(1,1,1,'h101,1,2,'hB2,2, 1,1,0, 1,1,'h101));
    vecs.push_back(mk(1,1,1,'h102,0,0,0,2,    1,1,1, 1,1,'h102));
    vecs.push_back(mk(1,1,1,'h103,0,0,0,2,    1,1,1, 1,1,'h103));
    vecs.push_back(mk(1,1,1,'h104,0,0,0,2,    1,1,1, 1,1,'h104));
    vecs.push_back(mk(1,1,1,'h105,0,0,0,2,    0,1,1, 1,2,'hB2));
    vecs.push_back(mk(1,1,1,'h105,0,0,0,2,    1,1,0, 1,1,'h105));
    // Same-register conflict
    vecs.push_back(mk(1,1,3,'h33,1,9,'h11,9,  1,1,0, 1,3,'h33));
    vecs.push_back(mk(1,1,9,'h22,0,0,0,9,     0,1,1, 1,9,'h11));
    vecs.push_back(mk(1,1,9,'h22,0,0,0,9,     1,1,0, 1,9,'h22));
    // Fill to full while A is valid, then drain
    vecs.push_back(mk(1,1,4,'h41,1,10,'hA0,13, 1,1,0, 1,4,'h41));
    vecs.push_back(mk(1,1,4,'h42,1,11,'hA1,13, 1,1,0, 1,4,'h42));
    vecs.push_back(mk(1,1,4,'h43,1,12,'hA2,13, 1,1,0, 1,4,'h43));
    vecs.push_back(mk(1,1,4,'h44,1,13,'hA3,13, 1,1,0, 1,4,'h44));
    vecs.push_back(mk(1,1,4,'h45,1,14,'hA4,13, 0,0,1, 1,10,'hA0));
    vecs.push_back(mk(1,0,0,0,1,14,'hA4,13,    0,1,1, 1,11,'hA1));
    vecs.push_back(mk(1,0,0,0,0,0,0,13,        0,1,1, 1,12,'hA2));
    vecs.push_back(mk(1,0,0,0,0,0,0,13,        0,1,1, 1,13,'hA3));
    vecs.push_back(mk(1,0,0,0,0,0,0,13,        0,1,0, 1,14,'hA4));
    // x0 on both ports
    vecs.push_back(mk(1,0,0,0,1,0,'hFF,0,      1,1,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,         1,1,0, 0,0,0));
    vecs.push_back(mk(1,1,0,'h77,0,0,0,0,      1,1,0, 0,0,0));
    // Freeze with counter at 1; force must land exactly two A wins after thaw
    vecs.push_back(mk(1,1,6,'h61,1,8,'h81,8,   1,1,0, 1,6,'h61));
    vecs.push_back(mk(1,1,6,'h62,0,0,0,8,      1,1,1, 1,6,'h62));
    repeat (3) vecs.push_back(mk(0,1,6,'h63,1,9,'h91,8, 0,0,1, 0,0,0));
    vecs.push_back(mk(1,1,6,'h63,0,0,0,8,      1,1,1, 1,6,'h63));
    vecs.push_back(mk(1,1,6,'h64,0,0,0,8,      1,1,1, 1,6,'h64));
    vecs.push_back(mk(1,1,6,'h65,0,0,0,8,      0,1,1, 1,8,'h81));
    vecs.push_back(mk(1,1,6,'h65,0,0,0,8,      1,1,0, 1,6,'h65));
    // Burst before mid-operation reset
    vecs.push_back(mk(1,1,6,'h66,1,20,'hC0,20, 1,1,0, 1,6,'h66));
    vecs.push_back(mk(1,1,6,'h67,1,21,'hC1,20, 1,1,1, 1,6,'h67));
    // After reset: queued x21 is gone
    vecs.push_back(mk(1,0,0,0,0,0,0,21,        1,1,0, 0,0,0));

    // Reset state
    rst_in = 1'b1; rdy_in = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0; busy_addr = '0;
    #2;
    chk("rst_we", 0, 32'(write_enable), 32'd0);
    chk("rst_wa", 0, 32'(write_addr), 32'd0);
    chk("rst_wd", 0, write_data, 32'd0);
    chk("rst_a_ready", 0, 32'(a_ready), 32'd1);
    chk("rst_b_ready", 0, 32'(b_ready), 32'd1);
    chk("rst_busy", 0, 32'(busy_hit), 32'd0);
    rdy_in = 1'b0;
    #1;
    chk("rst_a_ready_frz", 0, 32'(a_ready), 32'd0);
    chk("rst_b_ready_frz", 0, 32'(b_ready), 32'd0);
    rdy_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    for (int i = 0; i < 38; i++) step(i, vecs[i]);

    // Asynchronous reset mid-burst, after the last write pulse was observed
    #5;
    rst_in = 1'b1;
    #1;
    chk("arst_we", 38, 32'(write_enable), 32'd0);
    chk("arst_wa", 38, 32'(write_addr), 32'd0);
    chk("arst_wd", 38, write_data, 32'd0);
    chk("arst_busy", 38, 32'(busy_hit), 32'd0);
    chk("arst_a_ready", 38, 32'(a_ready), 32'd1);
    chk("arst_b_ready", 38, 32'(b_ready), 32'd1);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    step(38, vecs[38]);

    @(negedge clk_in);
    #1;
    chk("sb_empty", 0, 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
